// File: rtl/majority_voter_tmr.sv
// Purpose: registered N-way bitwise majority voter with per-channel fault tracking and exclusion.
// Latency: 1 cycle from in_valid/in_data to out_valid/out_data/mismatch/tie; fault flags set on the same edge.
// Backpressure: none; every in_valid word is accepted and voted, downstream must take each out_valid pulse.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_data   word to vote; channel i at in_data[i*W +: W]
//   clr_fault           pulse: clears fault flags and mismatch counters at the next edge
//   out_valid, out_data voted word (single-cycle valid pulse)
//   mismatch, tie       per-channel disagreement and any-bit-tie for the last valid word
//   fault, all_fault    sticky per-channel fault flags, and "every channel faulted"
// Optional: define MAJORITY_VOTER_STATS_EN to add vote_count / disagree_count outputs.
module majority_voter_tmr #(
    parameter int N            = 3,
    parameter int W            = 8,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic             clr_fault,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [N-1:0]     mismatch,
    output logic             tie,
    output logic [N-1:0]     fault,
    output logic             all_fault
`ifdef MAJORITY_VOTER_STATS_EN
    ,
    output logic [31:0]      vote_count,
    output logic [31:0]      disagree_count
`endif
);

    // Wide enough to hold a count of 0..N channels.
    localparam int CW = $clog2(N + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   THRESH  = (CNT_W + 1)'(FAULT_THRESH);

    if ((N % 2 == 0) || (N < 3)) begin : g_bad_n
        $error("majority_voter_tmr: N must be odd and >= 3 (N=%0d)", N);
    end
    if ((FAULT_THRESH < 1) || (FAULT_THRESH > (2 ** CNT_W) - 1)) begin : g_bad_thresh
        $error("majority_voter_tmr: FAULT_THRESH out of range for CNT_W");
    end

    logic [W-1:0]     out_data_q;
    logic             out_valid_q;
    logic [N-1:0]     mismatch_q;
    logic             tie_q;
    logic [N-1:0]     fault_q;
    logic [CNT_W-1:0] cnt_q [N];

    logic [N-1:0]     active;
    logic [CW-1:0]    act_cnt;
    logic [CW-1:0]    ones;
    logic [W-1:0]     vote;
    logic             tie_c;
    logic [N-1:0]     mm_c;

    assign active = ~fault_q;

    always_comb begin
        act_cnt = '0;
        for (int i = 0; i < N; i++) begin
            act_cnt = act_cnt + CW'(active[i]);
        end
    end

    // Per-bit vote over active channels: compare 2*ones against the active
    // count so the even-A tie case falls out without a division.
    always_comb begin
        vote  = out_data_q;
        tie_c = 1'b0;
        ones  = '0;
        for (int b = 0; b < W; b++) begin
            ones = '0;
            for (int i = 0; i < N; i++) begin
                ones = ones + CW'(active[i] & in_data[i*W + b]);
            end
            if ({ones, 1'b0} > {1'b0, act_cnt}) begin
                vote[b] = 1'b1;
            end else if ({ones, 1'b0} < {1'b0, act_cnt}) begin
                vote[b] = 1'b0;
            end else begin
                // Tie: hold the previous bit. With no active channel at all
                // (all faulted) every bit "ties" trivially; that is not reported.
                vote[b] = out_data_q[b];
                if (act_cnt != '0) begin
                    tie_c = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mm_c = '0;
        for (int i = 0; i < N; i++) begin
            mm_c[i] = active[i] & (in_data[i*W +: W] != vote);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mismatch_q  <= '0;
            tie_q       <= 1'b0;
            fault_q     <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_data_q <= vote;
                mismatch_q <= mm_c;
                tie_q      <= tie_c;
            end
            // Clear wins over any fault declared by the same word, and that
            // word's counts are dropped.
            if (clr_fault) begin
                fault_q <= '0;
                for (int i = 0; i < N; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (in_valid) begin
                for (int i = 0; i < N; i++) begin
                    if (mm_c[i]) begin
                        if (cnt_q[i] != CNT_MAX) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                        if (({1'b0, cnt_q[i]} + 1'b1) >= THRESH) begin
                            fault_q[i] <= 1'b1;
                        end
                    end else if (active[i]) begin
                        cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mismatch  = mismatch_q;
    assign tie       = tie_q;
    assign fault     = fault_q;
    assign all_fault = &fault_q;

`ifdef MAJORITY_VOTER_STATS_EN
    logic [31:0] vote_cnt_q;
    logic [31:0] dis_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_cnt_q <= '0;
            dis_cnt_q  <= '0;
        end else if (in_valid) begin
            vote_cnt_q <= vote_cnt_q + 32'd1;
            if ((|mm_c) && (dis_cnt_q != 32'hFFFF_FFFF)) begin
                dis_cnt_q <= dis_cnt_q + 32'd1;
            end
        end
    end

    assign vote_count     = vote_cnt_q;
    assign disagree_count = dis_cnt_q;
`endif

endmodule
